// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: shared period counter, double-buffered config.
// Optional per-period duty ramp (soft start) when PWM_RAMP_EN is defined.
module pwm_multi_gen #(
    parameter int CHANNELS  = 2,
    parameter int DUTY_W    = 10,
    parameter int PERIOD_W  = 32,
    parameter int RAMP_STEP = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_load,
    input  logic [PERIOD_W-1:0]        period_in,
    input  logic [CHANNELS*DUTY_W-1:0] duty_in,
    input  logic [CHANNELS-1:0]        en_in,
    output logic [CHANNELS-1:0]        pwm,
    output logic                       period_tick,
    output logic                       cfg_pending
);
    localparam int PROD_W = PERIOD_W + DUTY_W;

    logic [PERIOD_W-1:0]        r_cnt;
    logic [PERIOD_W-1:0]        r_period;
    logic [CHANNELS-1:0]        r_en;
    logic [PERIOD_W-1:0]        r_pend_period;
    logic [CHANNELS*DUTY_W-1:0] r_pend_duty;
    logic [CHANNELS-1:0]        r_pend_en;
    logic                       r_pending;
    logic [CHANNELS-1:0]        r_pwm;
    logic                       r_tick;

    logic                       w_running;
    logic                       w_wrap;
    logic                       w_apply;
    logic [PERIOD_W-1:0]        w_per_nxt;
    logic [CHANNELS-1:0]        w_hit;

    assign w_running = (r_period >= PERIOD_W'(2));
    assign w_wrap    = w_running && (r_cnt == r_period - PERIOD_W'(1));
    assign w_apply   = r_pending && (!w_running || w_wrap);
    assign w_per_nxt = w_apply ? r_pend_period : r_period;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [DUTY_W-1:0]   w_pend_duty;
        logic [DUTY_W-1:0]   w_cur_nxt;
        logic                w_upd;
        logic [PROD_W-1:0]   w_prod;
        logic [PERIOD_W-1:0] r_cmp;

        assign w_pend_duty = r_pend_duty[g*DUTY_W +: DUTY_W];
`ifdef PWM_RAMP_EN
        logic [DUTY_W-1:0] r_tgt;
        logic [DUTY_W-1:0] r_cur;
        logic [DUTY_W-1:0] w_tgt;
        logic [DUTY_W-1:0] w_gap;
        logic [DUTY_W-1:0] w_mv;

        assign w_tgt = w_apply ? w_pend_duty : r_tgt;
        assign w_upd = w_apply || w_wrap;

        // Step the current duty toward the target, never overshooting
        always_comb begin
            w_gap     = (w_tgt >= r_cur) ? (w_tgt - r_cur) : (r_cur - w_tgt);
            w_mv      = (w_gap > DUTY_W'(RAMP_STEP)) ? DUTY_W'(RAMP_STEP) : w_gap;
            w_cur_nxt = (w_tgt >= r_cur) ? (r_cur + w_mv) : (r_cur - w_mv);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_tgt <= '0;
                r_cur <= '0;
            end else begin
                if (w_apply) r_tgt <= w_pend_duty;
                if (w_upd)   r_cur <= w_cur_nxt;
            end
        end
`else
        assign w_cur_nxt = w_pend_duty;
        assign w_upd     = w_apply;
`endif
        // Full-width product so the shift never loses high bits
        assign w_prod = PROD_W'(w_per_nxt) * PROD_W'(w_cur_nxt);

        always_ff @(posedge clk) begin
            if (reset)      r_cmp <= '0;
            else if (w_upd) r_cmp <= PERIOD_W'(w_prod >> DUTY_W);
        end

        assign w_hit[g] = r_en[g] && (r_cnt < r_cmp);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_period      <= '0;
            r_en          <= '0;
            r_pend_period <= '0;
            r_pend_duty   <= '0;
            r_pend_en     <= '0;
            r_pending     <= 1'b0;
            r_pwm         <= '0;
            r_tick        <= 1'b0;
        end else begin
            r_cnt  <= (!w_running || w_wrap) ? '0 : r_cnt + PERIOD_W'(1);
            r_pwm  <= w_running ? w_hit : '0;
            r_tick <= w_running && (r_cnt == '0);
            if (w_apply) begin
                r_period <= r_pend_period;
                r_en     <= r_pend_en;
            end
            // A load on the apply edge becomes the next pending config
            if (cfg_load) begin
                r_pend_period <= period_in;
                r_pend_duty   <= duty_in;
                r_pend_en     <= en_in;
                r_pending     <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign pwm         = r_pwm;
    assign period_tick = r_tick;
    assign cfg_pending = r_pending;
endmodule

// File: tb/tb_pwm_multi_gen.sv
// Directed testbench for pwm_multi_gen (2 channels, 10-bit duty).
// Ramp scenario runs only when PWM_RAMP_EN is defined.
module tb_pwm_multi_gen;
    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_load;
    logic [31:0] period_in;
    logic [19:0] duty_in;
    logic [1:0]  en_in;
    logic [1:0]  pwm;
    logic        period_tick;
    logic        cfg_pending;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pwm_multi_gen #(
        .CHANNELS (2),
        .DUTY_W   (10),
        .PERIOD_W (32),
        .RAMP_STEP(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_load   (cfg_load),
        .period_in  (period_in),
        .duty_in    (duty_in),
        .en_in      (en_in),
        .pwm        (pwm),
        .period_tick(period_tick),
        .cfg_pending(cfg_pending)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cfg(input int p, input int d0, input int d1,
                             input logic [1:0] en);
        period_in = 32'(p);
        duty_in   = {10'(d1), 10'(d0)};
        en_in     = en;
        cfg_load  = 1'b1;
    endtask

    task automatic load(input int p, input int d0, input int d1,
                        input logic [1:0] en);
        drive_cfg(p, d0, d1, en);
        step();
        cfg_load = 1'b0;
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            step();
            ok = period_tick;
        end
    endtask

    task automatic measure(input int p, output int h0, output int h1,
                           output int nt);
        h0 = 0;
        h1 = 0;
        nt = 0;
        for (int k = 0; k < p; k++) begin
            h0 += int'(pwm[0]);
            h1 += int'(pwm[1]);
            nt += int'(period_tick);
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_cfg(100, 512, 512, 2'b11);
        step();
        step();
        cfg_load = 1'b0;
        step();
        n_vec++;
        if (pwm !== 2'b00) begin
            n_err++;
            $display("FAIL reset_pwm got=%b exp=00", pwm);
        end
        n_vec++;
        if (period_tick !== 1'b0) begin
            n_err++;
            $display("FAIL reset_tick got=%b exp=0", period_tick);
        end
        n_vec++;
        if (cfg_pending !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pending got=%b exp=0", cfg_pending);
        end
        reset = 1'b0;
        step();
        step();
        n_vec++;
        if (cfg_pending !== 1'b0 || period_tick !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle got=%b%b exp=00", cfg_pending, period_tick);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int h0, h1, nt;
        load(100, 512, 256, 2'b11);
        n_vec++;
        if (cfg_pending !== 1'b1) begin
            n_err++;
            $display("FAIL basic_pending got=%b exp=1", cfg_pending);
        end
        wait_tick(ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL basic_tick_timeout got=0 exp=1");
        end
        for (int r = 0; r < 2; r++) begin
            measure(100, h0, h1, nt);
            n_vec++;
            if (h0 !== 50 || h1 !== 25 || nt !== 1) begin
                n_err++;
                $display("FAIL basic_run%0d got=%0d/%0d/%0d exp=50/25/1",
                         r, h0, h1, nt);
            end
            n_vec++;
            if (period_tick !== 1'b1) begin
                n_err++;
                $display("FAIL basic_next_tick%0d got=%b exp=1", r, period_tick);
            end
        end
    endtask

    task automatic test_extremes();
        bit ok;
        int h0, h1, nt;
        load(100, 0, 1023, 2'b11);
        wait_tick(ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL ext_tick_timeout got=0 exp=1");
        end
        measure(100, h0, h1, nt);
        n_vec++;
        if (h0 !== 0 || h1 !== 99 || nt !== 1) begin
            n_err++;
            $display("FAIL extremes got=%0d/%0d/%0d exp=0/99/1", h0, h1, nt);
        end
    endtask

    task automatic test_midreload();
        bit ok;
        int h0, h1, nt;
        load(100, 512, 256, 2'b11);
        wait_tick(ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL mid_tick_timeout got=0 exp=1");
        end
        h0 = 0;
        for (int k = 0; k < 100; k++) begin
            h0 += int'(pwm[0]);
            if (k == 50) begin
                n_vec++;
                if (cfg_pending !== 1'b1) begin
                    n_err++;
                    $display("FAIL mid_pending_high got=%b exp=1", cfg_pending);
                end
            end
            if (k == 99) begin
                n_vec++;
                if (cfg_pending !== 1'b0) begin
                    n_err++;
                    $display("FAIL mid_pending_clear got=%b exp=0", cfg_pending);
                end
            end
            if (k == 29) drive_cfg(200, 768, 256, 2'b11);
            if (k == 30) cfg_load = 1'b0;
            step();
        end
        n_vec++;
        if (h0 !== 50 || period_tick !== 1'b1) begin
            n_err++;
            $display("FAIL mid_old_period got=%0d/%b exp=50/1", h0, period_tick);
        end
        measure(200, h0, h1, nt);
        n_vec++;
        if (h0 !== 150 || h1 !== 50 || nt !== 1) begin
            n_err++;
            $display("FAIL mid_new_period got=%0d/%0d/%0d exp=150/50/1",
                     h0, h1, nt);
        end
    endtask

    task automatic test_load_on_wrap();
        int h0, h1, nt;
        load(100, 256, 512, 2'b11);
        for (int k = 1; k < 198; k++) step();
        drive_cfg(80, 512, 0, 2'b01);
        step();
        cfg_load = 1'b0;
        n_vec++;
        if (cfg_pending !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_pending got=%b exp=1", cfg_pending);
        end
        step();
        n_vec++;
        if (period_tick !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_tick got=%b exp=1", period_tick);
        end
        measure(100, h0, h1, nt);
        n_vec++;
        if (h0 !== 25 || h1 !== 50 || nt !== 1) begin
            n_err++;
            $display("FAIL wrap_older_cfg got=%0d/%0d/%0d exp=25/50/1",
                     h0, h1, nt);
        end
        n_vec++;
        if (cfg_pending !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_pending_clear got=%b exp=0", cfg_pending);
        end
        measure(80, h0, h1, nt);
        n_vec++;
        if (h0 !== 40 || h1 !== 0 || nt !== 1) begin
            n_err++;
            $display("FAIL wrap_newer_cfg got=%0d/%0d/%0d exp=40/0/1",
                     h0, h1, nt);
        end
    endtask

    task automatic test_stop();
        int hi, nt;
        load(1, 512, 512, 2'b11);
        for (int k = 0; k < 100; k++) step();
        hi = 0;
        nt = 0;
        for (int k = 0; k < 200; k++) begin
            hi += int'(pwm[0]) + int'(pwm[1]);
            nt += int'(period_tick);
            step();
        end
        n_vec++;
        if (hi !== 0 || nt !== 0) begin
            n_err++;
            $display("FAIL stop got=%0d/%0d exp=0/0", hi, nt);
        end
        n_vec++;
        if (cfg_pending !== 1'b0) begin
            n_err++;
            $display("FAIL stop_pending got=%b exp=0", cfg_pending);
        end
    endtask

    task automatic test_reset_mid();
        int hi, nt;
        load(100, 512, 256, 2'b11);
        step();
        n_vec++;
        if (period_tick !== 1'b0) begin
            n_err++;
            $display("FAIL rst_apply_tick got=%b exp=0", period_tick);
        end
        step();
        n_vec++;
        if (period_tick !== 1'b1) begin
            n_err++;
            $display("FAIL rst_first_tick got=%b exp=1", period_tick);
        end
        for (int k = 0; k < 10; k++) step();
        load(200, 100, 100, 2'b11);
        for (int k = 11; k < 39; k++) step();
        n_vec++;
        if (pwm !== 2'b01 || cfg_pending !== 1'b1) begin
            n_err++;
            $display("FAIL rst_before got=%b/%b exp=01/1", pwm, cfg_pending);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_vec++;
        if (pwm !== 2'b00 || period_tick !== 1'b0 || cfg_pending !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid got=%b/%b/%b exp=00/0/0",
                     pwm, period_tick, cfg_pending);
        end
        hi = 0;
        nt = 0;
        for (int k = 0; k < 150; k++) begin
            hi += int'(pwm[0]) + int'(pwm[1]);
            nt += int'(period_tick);
            step();
        end
        n_vec++;
        if (hi !== 0 || nt !== 0) begin
            n_err++;
            $display("FAIL rst_discard got=%0d/%0d exp=0/0", hi, nt);
        end
    endtask

    task automatic test_ramp();
        bit ok;
        int h0, h1, nt;
        int exp_hi [5] = '{1, 3, 4, 6, 6};
        reset = 1'b1;
        step();
        reset = 1'b0;
        load(100, 64, 64, 2'b11);
        wait_tick(ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL ramp_tick_timeout got=0 exp=1");
        end
        for (int p = 0; p < 5; p++) begin
            measure(100, h0, h1, nt);
            n_vec++;
            if (h0 !== exp_hi[p] || h1 !== exp_hi[p] || nt !== 1) begin
                n_err++;
                $display("FAIL ramp_p%0d got=%0d/%0d/%0d exp=%0d/%0d/1",
                         p, h0, h1, nt, exp_hi[p], exp_hi[p]);
            end
        end
    endtask

    initial begin
        #300us;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        cfg_load  = 1'b0;
        period_in = '0;
        duty_in   = '0;
        en_in     = '0;
        test_reset();
`ifdef PWM_RAMP_EN
        test_ramp();
`else
        test_basic();
        test_extremes();
        test_midreload();
        test_load_on_wrap();
        test_stop();
        test_reset_mid();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pwm_multi_gen.md
Name: pwm_multi_gen

Overview:
- Multi-channel PWM generator, parametrised successor of the single-channel PWM generator.
- One shared period counter per instance; CHANNELS independent duty comparators.
- Period and duty configuration is double-buffered: a load strobe captures new values, and they take effect only at a period boundary, so the output never glitches mid-period.
- Sits between the motor/servo control FSMs and the output pins.

Parameters:
- CHANNELS, 2, number of PWM outputs (1..16).
- DUTY_W, 10, duty resolution in bits; full scale is 2^DUTY_W.
- PERIOD_W, 32, width of the period-in-clocks field.
- RAMP_STEP, 16, duty change per period when PWM_RAMP_EN is defined.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high reset.
- cfg_load  in  1  one-cycle strobe; captures period_in, duty_in and en_in into the pending buffer.
- period_in  in  PERIOD_W  PWM period in clk cycles.
- duty_in  in  CHANNELS*DUTY_W  packed duties; channel i occupies [i*DUTY_W +: DUTY_W].
- en_in  in  CHANNELS  per-channel enable.
- pwm  out  CHANNELS  registered PWM outputs.
- period_tick  out  1  one-cycle pulse at each period start.
- cfg_pending  out  1  high while captured config waits for a boundary.

Behaviour:
- Reset (sync, active-high, wins over all other inputs):
  - outputs: pwm=0, period_tick=0, cfg_pending=0;
  - internal state: counter cnt=0, active period=0, active/pending duties=0, enables=0.
- Active period P < 2 ("stopped"):
  - cnt held at 0, pwm=0, period_tick=0;
  - a pending config is applied on the next clock edge.
- Running (P >= 2):
  - cnt counts 0..P-1 and wraps to 0.
  - Wrap edge = the edge on which cnt==P-1.
- Compare value per channel:
  - cmp[i] = (P * duty[i]) >> DUTY_W.
  - Product width is PERIOD_W+DUTY_W with no truncation before the shift.
  - cmp[i] is computed when the config is applied and registered; no divider is used.
- Output timing:
  - pwm[i] is updated on each edge as pwm[i] <= en[i] && (cnt < cmp[i]), so it lags cnt by one cycle.
  - Per period, pwm[i] is high for exactly cmp[i] consecutive cycles, starting on the cycle after cnt==0.
  - duty=0 gives constant low.
  - duty=2^DUTY_W-1 gives P-1 high cycles; 100% duty is not reachable by design.
- period_tick:
  - Registered; high for one cycle, aligned with the pwm cycle that reflects cnt==0.
  - Not asserted while stopped.
- Config update:
  - cfg_load on an edge latches the inputs into the pending buffer and sets cfg_pending.
  - A repeated cfg_load before a boundary overwrites the pending buffer (last write wins).
  - At the wrap edge, if cfg_pending is set: pending values are copied to active, cmp is recomputed, cnt restarts at 0, and cfg_pending clears.
  - The new P applies from the period that starts at that wrap.
- Simultaneous cfg_load and wrap edge:
  - The previously pending values (if any) are applied at this wrap.
  - The newly loaded values become pending, and cfg_pending stays high.
- Changing P from running to <2 takes effect at the wrap; pwm then goes low and stays low.
- Enable changes are applied at the boundary only, like duty.
- Reset mid-period: all channels go low on the next edge and the pending config is discarded.

Optional Feature:
- Macro: PWM_RAMP_EN.
- Defined:
  - Each channel keeps a target duty (from the applied config) and a current duty.
  - At every wrap edge, the current duty moves toward the target by min(RAMP_STEP, |target-current|), then cmp is recomputed from the current duty.
  - Current duty resets to 0, giving soft-start on motors.
  - cfg_pending does not wait for the ramp to finish.
- Undefined:
  - The current duty equals the target immediately at the boundary.
  - No ramp registers are synthesised.

Test Plan:
- Basic duty: CHANNELS=2, DUTY_W=10; load P=100, duty0=512, duty1=256, en=11 -> per period ch0 high 50 cycles, ch1 high 25 cycles, period_tick every 100 cycles.
- Extremes: duty0=0, duty1=1023, P=100 -> ch0 constant 0; ch1 high 99 cycles, low 1 cycle per period.
- Mid-period reload: running P=100, duty0=512; at cnt=30 load duty0=768, P=200 -> current period keeps 50 high of 100; the next period has 150 high of 200; cfg_pending is high from the load until the wrap.
- Load on wrap: assert cfg_load exactly on the cnt==P-1 edge while another config is pending -> the older config is applied and the new one stays pending one more period.
- Stop and reset: load P=1 -> pwm=0, no period_tick; with P=100 running, assert reset at cnt=40 -> pwm=0 and cfg_pending=0 on the next edge, counter at 0.
- Ramp (PWM_RAMP_EN, RAMP_STEP=16): target 64 from reset -> cmp steps through P*16/1024, P*32/1024, P*48/1024, P*64/1024 over 4 periods, then holds.
